// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink: VGA timing counters plus a two-stage pipeline that aligns
// sync and blanking with the drawer's one-clock-late draw/data.
module vga_pixel_sink #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter logic [5:0] BG_COLOR = 6'b010111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       draw,
    input  logic [5:0] data,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb,
    output logic       frame_tick
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [9:0] r_h_cnt, r_v_cnt;
    logic       r_active_d1, r_hs_d1, r_vs_d1;
    logic       r_hsync, r_vsync, r_frame_tick;
    logic [5:0] r_rgb;
    logic       w_h_last, w_v_last, w_active, w_hs, w_vs;

    assign w_h_last = r_h_cnt == 10'(H_TOTAL - 1);
    assign w_v_last = r_v_cnt == 10'(V_TOTAL - 1);
    assign w_active = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
    assign w_hs = !((r_h_cnt >= 10'(H_ACTIVE + H_FP)) && (r_h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
    assign w_vs = !((r_v_cnt >= 10'(V_ACTIVE + V_FP)) && (r_v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            r_active_d1  <= 1'b0;
            r_hs_d1      <= 1'b1;
            r_vs_d1      <= 1'b1;
            r_rgb        <= '0;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + 10'd1;
            if (w_h_last)
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
            r_active_d1  <= w_active;
            r_hs_d1      <= w_hs;
            r_vs_d1      <= w_vs;
            // draw/data belong to the coordinate now held in stage 1
            r_rgb        <= !r_active_d1 ? 6'b000000 : draw ? data : BG_COLOR;
            r_hsync      <= r_hs_d1;
            r_vsync      <= r_vs_d1;
            r_frame_tick <= (r_h_cnt == '0) && (r_v_cnt == 10'(V_ACTIVE));
        end
    end

    assign pixel_x    = r_h_cnt;
    assign pixel_y    = r_v_cnt;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign rgb        = r_rgb;
    assign frame_tick = r_frame_tick;
endmodule

// File: tb/tb_vga_pixel_sink.sv
// tb_vga_pixel_sink: randomized checks of vga_pixel_sink against a coordinate
// model, using a shrunken raster so whole frames fit in a short run.
module tb_vga_pixel_sink;
    localparam int HA = 20, HF = 3, HS = 5, HB = 4;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam logic [5:0] BG = 6'b010111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       draw = 1'b0;
    logic [5:0] data = '0;
    logic [9:0] pixel_x, pixel_y;
    logic       hsync, vsync, frame_tick;
    logic [5:0] rgb;

    int errors = 0;
    int checks = 0;
    int k = 0;
    logic [9:0] exp_x, exp_y;
    logic [5:0] exp_rgb;
    logic       exp_hs, exp_vs, exp_ft;

    vga_pixel_sink #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .draw(draw), .data(data),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // k counts edges since reset release; coordinate k mod FR is on pixel_x/y
    // after edge k, and rgb after edge k shows coordinate k-2 with the
    // draw/data that were sampled at edge k.
    task automatic advance(input logic d, input logic [5:0] dat);
        int c, h, v;
        draw = d;
        data = dat;
        @(posedge clk);
        #1;
        k++;
        c = k % FR;
        exp_x = 10'(c % HT);
        exp_y = 10'(c / HT);
        exp_ft = ((k - 1) % FR) == VA * HT;
        if (k >= 2) begin
            c = (k - 2) % FR;
            h = c % HT;
            v = c / HT;
            exp_rgb = (h < HA && v < VA) ? (d ? dat : BG) : 6'b000000;
            exp_hs = !(h >= HA + HF && h < HA + HF + HS);
            exp_vs = !(v >= VA + VF && v < VA + VF + VS);
        end else begin
            exp_rgb = 6'b000000;
            exp_hs = 1'b1;
            exp_vs = 1'b1;
        end
    endtask

    task automatic restart();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({pixel_x, pixel_y, rgb, hsync, vsync, frame_tick} !== {20'd0, 6'd0, 3'b110}) begin
            errors++;
            $display("FAIL reset_hold: x=%0d y=%0d rgb=%b hs=%b vs=%b ft=%b, need 0 0 000000 1 1 0",
                     pixel_x, pixel_y, rgb, hsync, vsync, frame_tick);
        end
        rst_n = 1'b1;
        k = 0;
        #1;
        checks++;
        if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
            errors++;
            $display("FAIL reset_release: x=%0d y=%0d, need 0 0", pixel_x, pixel_y);
        end
    endtask

    task automatic test_free_run();
        int falls = 0, vs_low = 0, ticks = 0, run = 0;
        logic prev_hs = 1'b1;
        restart();
        for (int i = 0; i < 2 * FR + 2; i++) begin
            advance(1'b0, 6'($urandom));
            checks++;
            if ({pixel_x, pixel_y, rgb, hsync, vsync, frame_tick} !== {exp_x, exp_y, exp_rgb, exp_hs, exp_vs, exp_ft}) begin
                errors++;
                $display("FAIL free_run k=%0d: x=%0d y=%0d rgb=%b hs=%b vs=%b ft=%b, need %0d %0d %b %b %b %b",
                         k, pixel_x, pixel_y, rgb, hsync, vsync, frame_tick,
                         exp_x, exp_y, exp_rgb, exp_hs, exp_vs, exp_ft);
            end
            if (k > 2 && k <= FR + 2) begin
                falls += (prev_hs && !hsync) ? 1 : 0;
                vs_low += vsync ? 0 : 1;
                ticks += frame_tick ? 1 : 0;
            end
            if (!hsync) run++;
            if (hsync && !prev_hs) begin
                checks++;
                if (run != HS) begin
                    errors++;
                    $display("FAIL hsync_width: got %0d clocks, need %0d", run, HS);
                end
                run = 0;
            end
            prev_hs = hsync;
        end
        checks++;
        if (falls != VT || vs_low != VS * HT || ticks != 1) begin
            errors++;
            $display("FAIL frame_counts: hs_pulses=%0d vs_low=%0d ticks=%0d, need %0d %0d 1",
                     falls, vs_low, ticks, VT, VS * HT);
        end
    endtask

    task automatic test_single_pixel();
        int hits = 0;
        restart();
        for (int i = 0; i < FR + 4; i++) begin
            advance(k >= 1 && ((k - 1) % FR) == 5 * HT + 10, 6'b110000);
            checks++;
            if (rgb !== exp_rgb || pixel_x !== exp_x || pixel_y !== exp_y) begin
                errors++;
                $display("FAIL single_pixel k=%0d: x=%0d y=%0d rgb=%b, need %0d %0d %b",
                         k, pixel_x, pixel_y, rgb, exp_x, exp_y, exp_rgb);
            end
            hits += (rgb == 6'b110000) ? 1 : 0;
        end
        checks++;
        if (hits != 1) begin
            errors++;
            $display("FAIL single_pixel_count: got %0d, need 1", hits);
        end
    endtask

    task automatic test_full_draw();
        int blanks = 0;
        restart();
        for (int i = 0; i < FR + 2; i++) begin
            advance(1'b1, 6'b111111);
            checks++;
            if ({rgb, hsync, vsync} !== {exp_rgb, exp_hs, exp_vs}) begin
                errors++;
                $display("FAIL full_draw k=%0d: rgb=%b hs=%b vs=%b, need %b %b %b",
                         k, rgb, hsync, vsync, exp_rgb, exp_hs, exp_vs);
            end
            if (k > 2) blanks += (rgb == 6'b000000) ? 1 : 0;
        end
        checks++;
        if (blanks != FR - HA * VA) begin
            errors++;
            $display("FAIL full_draw_blanks: got %0d, need %0d", blanks, FR - HA * VA);
        end
    endtask

    task automatic test_random_draw();
        restart();
        for (int i = 0; i < FR + 40; i++) begin
            advance(1'($urandom), 6'($urandom));
            checks++;
            if ({pixel_x, pixel_y, rgb, hsync, vsync, frame_tick} !== {exp_x, exp_y, exp_rgb, exp_hs, exp_vs, exp_ft}) begin
                errors++;
                $display("FAIL random_draw k=%0d: x=%0d y=%0d rgb=%b hs=%b vs=%b ft=%b, need %0d %0d %b %b %b %b",
                         k, pixel_x, pixel_y, rgb, hsync, vsync, frame_tick,
                         exp_x, exp_y, exp_rgb, exp_hs, exp_vs, exp_ft);
            end
        end
    endtask

    task automatic test_mid_reset();
        restart();
        for (int i = 0; i < FR && !(exp_x == 10'd13 && exp_y == 10'd7); i++)
            advance(1'b1, 6'b101010);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pixel_x, pixel_y, rgb, hsync, vsync, frame_tick} !== {20'd0, 6'd0, 3'b110}) begin
            errors++;
            $display("FAIL mid_reset_async: x=%0d y=%0d rgb=%b hs=%b vs=%b ft=%b, need 0 0 000000 1 1 0",
                     pixel_x, pixel_y, rgb, hsync, vsync, frame_tick);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pixel_x !== 10'(i) || pixel_y !== 10'd0) begin
                errors++;
                $display("FAIL mid_reset_restart: x=%0d y=%0d, need %0d 0", pixel_x, pixel_y, i);
            end
            advance(1'b0, 6'd0);
        end
        checks++;
        if (rgb !== exp_rgb) begin
            errors++;
            $display("FAIL mid_reset_first_rgb: rgb=%b, need %b", rgb, exp_rgb);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_single_pixel();
        test_full_draw();
        test_random_draw();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_pixel_sink.md
VGA_PIXEL_SINK -- requirements
Module: vga_pixel_sink

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in clocks.
- H_SYNC, 96, hsync pulse width in clocks.
- H_BP, 48, horizontal back porch in clocks.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines.
- BG_COLOR, 6'b010111, background RRGGBB.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, pixel clock.
- rst_n, in, 1, asynchronous active-low reset.
- draw, in, 1, registered drawer flag; object pixel present.
- data, in, 6, registered drawer colour, RRGGBB.
- pixel_x, out, 10, current horizontal counter.
- pixel_y, out, 10, current vertical counter.
- hsync, out, 1, horizontal sync, active-low.
- vsync, out, 1, vertical sync, active-low.
- rgb, out, 6, pixel colour to DAC, RRGGBB.
- frame_tick, out, 1, one-clock pulse at start of vertical blank.

REQ-003 Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.

Function
REQ-004 Counters:
- h_cnt counts 0..H_TOTAL-1, where H_TOTAL = sum of H_* (800).
- h_cnt wraps to 0 after H_TOTAL-1.
- v_cnt increments only on the clock where h_cnt wraps.
- v_cnt counts 0..V_TOTAL-1 (525) and then wraps to 0.

REQ-005 pixel_x SHALL equal h_cnt and pixel_y SHALL equal v_cnt, both driven directly from the counter registers with zero added latency.

REQ-006 Stage-0 signals, all derived from the counters:
- active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
- hs_raw is low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vs_raw is low for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.

REQ-007 Drawer alignment: the drawer presents draw/data one clock after a coordinate is shown on pixel_x/pixel_y. Therefore:
- active, hs_raw and vs_raw SHALL pass through a one-stage delay register (stage 1), aligning them with draw/data.

REQ-008 Output register (stage 2) SHALL load every clock:
- If active_d1=0: rgb = 6'b000000.
- Else if draw=1: rgb = data.
- Else: rgb = BG_COLOR.
- hsync = hs_d1 and vsync = vs_d1, loaded at the same edge.

REQ-009 Total latency SHALL be exactly 2 clocks from a coordinate on pixel_x/pixel_y to its rgb, hsync and vsync values. All three outputs SHALL stay mutually aligned.

REQ-010 data SHALL be ignored whenever draw=0. The drawer holds stale data while draw=0, and that stale data SHALL never reach rgb.

REQ-011 frame_tick:
- Pulses high for exactly one clock when h_cnt=0 and v_cnt=V_ACTIVE.
- Is registered, so it is asserted on the clock after that counter state.
- Occurs once per frame.

REQ-012 Boundary behaviour:
- Simultaneous h and v wrap (h_cnt=799, v_cnt=524) SHALL give h_cnt=0, v_cnt=0 on the next clock.
- A draw pulse that falls in blanking SHALL produce rgb=0.
- At pixel (639,y), the following blank pixel SHALL still use its own active_d1=0.

REQ-013 No combinational path SHALL exist from draw/data to any output.

Reset
REQ-014 While rst_n=0, regardless of clk:
- h_cnt=0 and v_cnt=0.
- Stage-1 registers: active_d1=0, hs_d1=1, vs_d1=1.
- rgb=0, hsync=1, vsync=1, frame_tick=0.

REQ-015 Reset assertion mid-line or mid-frame SHALL clear all state immediately. After rst_n rises:
- Counting restarts at (0,0) on the first clk edge.
- The first visible pixel's rgb appears 2 clocks after that edge.

REQ-016 Reset release SHALL be synchronised externally. The block adds no synchroniser.

Verification
REQ-017 Scenario, reset release then free-run one frame:
- hsync low for exactly 96 clocks starting 658 clocks after the line start (656+2 latency).
- 525 hsync pulses per vsync period.
- vsync low for 2 lines.

REQ-018 Scenario, draw=1 and data=6'b110000 only on the clock after pixel_x=100, pixel_y=50 -> rgb=6'b110000 for exactly one clock, 2 clocks after that coordinate; neighbouring pixels show BG_COLOR.

REQ-019 Scenario, draw=1 and data=6'b111111 held constantly -> rgb=6'b111111 throughout active video and rgb=0 for all 160 blank clocks of each line and all of lines 480..524.

REQ-020 Scenario, run to h_cnt=799, v_cnt=524 -> next clock pixel_x=0 and pixel_y=0; frame_tick observed once per 420000 clocks, one clock after (0,480).

REQ-021 Scenario, assert rst_n=0 at (h=300, v=200) between clock edges -> outputs take reset values without a clock edge; after release, pixel_x sequence restarts 0,1,2.

REQ-022 Scenario, draw=0 with data toggling randomly during active video -> rgb constantly equals BG_COLOR.
